// File: rtl/ped_button_request.sv
// ped_button_request: synchronises and debounces the pedestrian push-button, latches one crossing
// request until ped_green answers, then enforces a lockout. Optional PED_BEEP_EN adds the beep port.
module ped_button_request #(
  parameter int TP          = 1,
  parameter int DEB_CYC     = 2,
  parameter int LOCKOUT_CYC = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic ped_green,
  output logic btn,
  output logic wait_lamp,
  output logic served
`ifdef PED_BEEP_EN
  ,
  output logic beep
`endif
);

  localparam int DW = ($clog2(DEB_CYC + 1) < 1) ? 1 : $clog2(DEB_CYC + 1);
  localparam int LW = ($clog2(LOCKOUT_CYC + 1) < 1) ? 1 : $clog2(LOCKOUT_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT_CYC);

  // TP kept only for parameter compatibility; registers are modelled without delay.
  if (TP < 0 || DEB_CYC < 1 || LOCKOUT_CYC < 0) begin : g_bad_param
    $error("ped_button_request: invalid parameter value");
  end

  typedef enum logic [1:0] {IDLE, REQ, SERVE, LOCK} state_t;

  logic          sync_a, sync_b;
  logic          deb_lvl, deb_lvl_d;
  logic [DW-1:0] deb_cnt;
  logic          press;

  state_t        state, state_nxt;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic          pend, pend_nxt;
  logic          served_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      deb_lvl   <= 1'b0;
      deb_lvl_d <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_a    <= btn_raw;
      sync_b    <= sync_a;
      deb_lvl_d <= deb_lvl;
      // Any edge where the synchronised level matches restarts the qualification run.
      if (sync_b == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl <= sync_b;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign press = deb_lvl & ~deb_lvl_d;

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    pend_nxt     = pend;
    served_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ped_green)  state_nxt = SERVE;
        else if (press) state_nxt = REQ;
      end
      REQ: begin
        if (ped_green) begin
          state_nxt  = SERVE;
          served_nxt = 1'b1;
        end
      end
      SERVE: begin
        if (!ped_green) begin
          state_nxt    = LOCK;
          lock_cnt_nxt = LOCK_INIT;
        end
      end
      LOCK: begin
        if (lock_cnt == '0) begin
          state_nxt = (pend || press) ? REQ : IDLE;
          pend_nxt  = 1'b0;
        end else begin
          lock_cnt_nxt = lock_cnt - LW'(1);
          if (press) pend_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      pend      <= 1'b0;
      btn       <= 1'b0;
      wait_lamp <= 1'b0;
      served    <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_cnt  <= lock_cnt_nxt;
      pend      <= pend_nxt;
      btn       <= (state_nxt == REQ);
      wait_lamp <= (state_nxt == REQ);
      served    <= served_nxt;
    end
  end

`ifdef PED_BEEP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beep <= 1'b0;
    else        beep <= (state == SERVE) ? ~beep : 1'b0;
  end
`endif

endmodule

// File: tb/tb_ped_button_request.sv
// Directed self-checking bench for ped_button_request (DEB_CYC=2, LOCKOUT_CYC=5).
module tb_ped_button_request;

  logic clk = 1'b0;
  logic rst_n, btn_raw, ped_green;
  logic btn, wait_lamp, served;
`ifdef PED_BEEP_EN
  logic beep;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  ped_button_request #(
    .TP(1),
    .DEB_CYC(2),
    .LOCKOUT_CYC(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .ped_green(ped_green),
    .btn(btn),
    .wait_lamp(wait_lamp),
    .served(served)
`ifdef PED_BEEP_EN
    ,
    .beep(beep)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; btn_raw = 1'b1; ped_green = 1'b0;

    // 1: reset with button held, then first press after release
    step(3);
    check("rst_btn", btn, 1'b0);
    check("rst_wait", wait_lamp, 1'b0);
    check("rst_served", served, 1'b0);
    rst_n = 1'b1;
    step(4);
    check("lat_edge4", btn, 1'b0);
    step(1);
    check("lat_edge5", btn, 1'b1);
    check("lat_wait", wait_lamp, 1'b1);
    ped_green = 1'b1;
    step(1);
    check("t1_serve_btn", btn, 1'b0);
    check("t1_served", served, 1'b1);
    ped_green = 1'b0;
    step(1);
    check("t1_served_pulse", served, 1'b0);
    step(20);
    check("hold_one_req", btn, 1'b0);
    btn_raw = 1'b0;
    step(8);

    // 2: bounce rejection, then a press with a one-cycle gap
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      step(1);
      check("bounce", btn, 1'b0);
    end
    btn_raw = 1'b0;
    step(4);
    for (int i = 0; i < 6; i++) begin
      btn_raw = (i != 3);
      step(1);
    end
    btn_raw = 1'b0;
    step(10);
    check("gap_req", btn, 1'b1);
    ped_green = 1'b1;
    step(1);
    check("gap_served", served, 1'b1);
    ped_green = 1'b0;
    step(12);
    check("gap_one_req", btn, 1'b0);

    // 3: clean 4-cycle press, held request, service
    btn_raw = 1'b1;
    step(4);
    check("t3_not_yet", btn, 1'b0);
    btn_raw = 1'b0;
    step(1);
    check("t3_req", btn, 1'b1);
    step(10);
    check("t3_held_btn", btn, 1'b1);
    check("t3_held_wait", wait_lamp, 1'b1);
    ped_green = 1'b1;
    step(1);
    check("t3_drop_btn", btn, 1'b0);
    check("t3_drop_wait", wait_lamp, 1'b0);
    check("t3_served", served, 1'b1);
`ifdef PED_BEEP_EN
    check("beep_first", beep, 1'b0);
`endif
    step(1);
    check("t3_served_once", served, 1'b0);
`ifdef PED_BEEP_EN
    check("beep_tick", beep, 1'b1);
    step(1);
    check("beep_tock", beep, 1'b0);
`endif

    // 4: press during SERVE is not latched
    btn_raw = 1'b1;
    step(4);
    btn_raw = 1'b0;
    step(4);
    check("t4_serve_btn", btn, 1'b0);
    ped_green = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t4_no_req", btn, 1'b0);
    end
`ifdef PED_BEEP_EN
    check("beep_off", beep, 1'b0);
`endif

    // 5: press during LOCK is held until the lockout expires
    btn_raw = 1'b1;
    step(4);
    btn_raw = 1'b0;
    step(1);
    check("t5_req", btn, 1'b1);
    step(8);
    ped_green = 1'b1;
    step(1);
    ped_green = 1'b0;
    step(1);
    btn_raw = 1'b1;
    step(4);
    btn_raw = 1'b0;
    step(1);
    check("t5_lock_hold", btn, 1'b0);
    step(1);
    check("t5_lock_exit", btn, 1'b1);
    check("t5_wait", wait_lamp, 1'b1);

    // 6: asynchronous reset discards the request
    rst_n = 1'b0;
    #1;
    check("t6_async_btn", btn, 1'b0);
    check("t6_async_wait", wait_lamp, 1'b0);
    #2;
    rst_n = 1'b1;
    step(10);
    check("t6_no_req", btn, 1'b0);
    check("t6_served", served, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
